// File: rtl/synth_pkg.sv
// Shared constants and helpers for the polyphonic PWM synth.
// Note table, waveform encoding and mixer width calculation.
// Pure declarations; no logic lives here.
package synth_pkg;

  // Phase increments for one octave of C major (equal temperament), C4 = 24'h00_4000.
  localparam logic [23:0] INC [8] = '{
    24'h00_4000,  // C
    24'h00_47D6,  // D
    24'h00_50A2,  // E
    24'h00_556E,  // F
    24'h00_5FE4,  // G
    24'h00_6BA2,  // A
    24'h00_78D1,  // B
    24'h00_8000   // C'
  };

  // sw[4:3] waveform select.
  typedef enum logic [1:0] {
    WF_SQUARE = 2'd0,
    WF_SAW    = 2'd1,
    WF_TRI    = 2'd2,
    WF_PULSE  = 2'd3
  } wave_t;

  // Width of an unsigned sum of nvoices products of a 4-bit wave and an env_w envelope.
  function automatic int mix_w(input int nvoices, input int env_w);
    return 4 + env_w + $clog2(nvoices);
  endfunction

endpackage

// File: rtl/synth_voice.sv
// One synth voice: phase accumulator, waveform decode, attack/release envelope, product.
// Latency: acc/env update on the tick edge; smp is combinational from those registers.
// Backpressure: none; advances only on tick/env_tick strobes from the top.
module synth_voice
  import synth_pkg::*;
#(
  parameter int IDX   = 0,
  parameter int ACC_W = 24,
  parameter int ENV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             env_tick,
  input  logic             key,
  input  logic [2:0]       oct,
  input  wave_t            wf,
  output logic             active,
  output logic [ENV_W+3:0] smp
);

  localparam logic [ACC_W-1:0] INC_I   = ACC_W'(INC[IDX]);
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [ACC_W-1:0] acc;
  logic [ENV_W-1:0] env;
  logic [ENV_W-1:0] env_nxt;
  logic [3:0]       ph;
  logic [3:0]       wv;

  // Envelope step: one up or down per env tick, saturating at both ends.
  always_comb begin
    env_nxt = env;
    if (env_tick) begin
      if (key) begin
        if (env != ENV_MAX) env_nxt = env + 1'b1;
      end else if (env != '0) begin
        env_nxt = env - 1'b1;
      end
    end
  end

  // Phase accumulator (wraps silently) and envelope/active registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      env    <= '0;
      active <= 1'b0;
    end else begin
      if (tick) acc <= acc + (INC_I << oct);
      env    <= env_nxt;
      active <= (env_nxt != '0);
    end
  end

  // Waveform decode from the top four phase bits, then scale by envelope.
  always_comb begin
    ph = acc[ACC_W-1 -: 4];
    case (wf)
      WF_SQUARE: wv = ph[3] ? 4'hF : 4'h0;
      WF_SAW:    wv = ph;
      WF_TRI:    wv = ph[3] ? {~ph[2:0], 1'b0} : {ph[2:0], 1'b0};
      default:   wv = (ph[3:2] == 2'b11) ? 4'hF : 4'h0;
    endcase
    smp = {{ENV_W{1'b0}}, wv} * {4'b0000, env};
  end

endmodule

// File: rtl/synth_poly_pwm.sv
// Polyphonic PWM synth top: tick counters, voice array, mixer(s), PWM output stage.
// Optional stereo spread is compiled in with `define SYNTH_STEREO_EN.
// Latency: duty latches at each sample period wrap; pwm pins are registered (+1 clock).
// Backpressure: none; free-running, outputs a new sample every 2^PWM_W clocks.
module synth_poly_pwm
  import synth_pkg::*;
#(
  parameter int NVOICES = 5,
  parameter int NSW     = 8,
  parameter int ACC_W   = 24,
  parameter int PWM_W   = 8,
  parameter int ENV_W   = 4,
  parameter int ENV_DIV = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSW-1:0]     sw,
  input  logic [NVOICES-1:0] note_en,
  output logic               pwm_l,
  output logic               pwm_r,
  output logic               sample_tick,
  output logic [NVOICES-1:0] active
);

  localparam int SMP_W = 4 + ENV_W;
  localparam int MIX_W = mix_w(NVOICES, ENV_W);
  localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENV_DIV - 1);
  localparam logic [PWM_W-1:0] CNT_MAX  = '1;

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] duty_l;
  logic [DIV_W-1:0] div_cnt;
  logic             env_tick;
  logic [1:0]       gain;
  logic [SMP_W-1:0] smp [NVOICES];
  logic [MIX_W-1:0] sum_all;
  logic [MIX_W-1:0] mix_l;
  logic             unused_sw;

`ifdef SYNTH_STEREO_EN
  logic [PWM_W-1:0] duty_r;
  logic [MIX_W-1:0] sum_even;
  logic [MIX_W-1:0] sum_odd;
  logic [MIX_W-1:0] mix_r;
`endif

  // Switch bits above the defined controls carry no meaning.
  assign unused_sw   = ^sw[NSW-1:7];
  assign gain        = sw[6:5];
  assign sample_tick = (cnt == CNT_MAX);
  assign env_tick    = sample_tick && (div_cnt == DIV_LAST);

  // Gain shift (gain 3 = no shift, gain 0 = >>3) then clamp to full-scale duty.
  function automatic logic [PWM_W-1:0] scale_sat(input logic [MIX_W-1:0] s,
                                                  input logic [1:0]       g);
    logic [MIX_W-1:0] sh;
    sh = s >> (2'd3 - g);
    if (sh > MIX_W'(CNT_MAX)) return CNT_MAX;
    return PWM_W'(sh);
  endfunction

  for (genvar g = 0; g < NVOICES; g++) begin : g_voice
    synth_voice #(
      .IDX   (g),
      .ACC_W (ACC_W),
      .ENV_W (ENV_W)
    ) u_voice (
      .clk      (clk),
      .rst      (rst),
      .tick     (sample_tick),
      .env_tick (env_tick),
      .key      (note_en[g]),
      .oct      (sw[2:0]),
      .wf       (wave_t'(sw[4:3])),
      .active   (active[g]),
      .smp      (smp[g])
    );
  end

  // Unsigned voice sums; widths leave headroom so no sum can overflow.
  always_comb begin
    sum_all = '0;
`ifdef SYNTH_STEREO_EN
    sum_even = '0;
    sum_odd  = '0;
`endif
    for (int i = 0; i < NVOICES; i++) begin
      sum_all = sum_all + MIX_W'(smp[i]);
`ifdef SYNTH_STEREO_EN
      if (i % 2 == 0) sum_even = sum_even + MIX_W'(smp[i]);
      else            sum_odd  = sum_odd  + MIX_W'(smp[i]);
`endif
    end
`ifdef SYNTH_STEREO_EN
    mix_l = sw[7] ? sum_even : sum_all;
    mix_r = sw[7] ? sum_odd  : sum_all;
`else
    mix_l = sum_all;
`endif
  end

  // Free-running period counter, envelope divider and per-period duty latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div_cnt <= '0;
      duty_l  <= '0;
`ifdef SYNTH_STEREO_EN
      duty_r  <= '0;
`endif
    end else begin
      cnt <= cnt + 1'b1;
      if (sample_tick) begin
        duty_l  <= scale_sat(mix_l, gain);
`ifdef SYNTH_STEREO_EN
        duty_r  <= scale_sat(mix_r, gain);
`endif
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
    end
  end

  // Registered PWM comparators; the mono right pin trails the left pin by one clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_l <= 1'b0;
      pwm_r <= 1'b0;
    end else begin
      pwm_l <= (cnt < duty_l);
`ifdef SYNTH_STEREO_EN
      pwm_r <= sw[7] ? (cnt < duty_r) : (cnt < duty_l);
`else
      pwm_r <= pwm_l;
`endif
    end
  end

endmodule

// File: tb/tb_synth_poly_pwm.sv
// Bench for synth_poly_pwm: cycle-level behavioural model plus directed literal checks.
// Runs with ENV_DIV=1 so envelope ramps complete in a few sample periods.
// Honours SYNTH_STEREO_EN the same way the design does.
`timescale 1ns/1ps
module tb_synth_poly_pwm;

  localparam int NV      = 5;
  localparam int ENV_DIV = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    sw = 8'h00;
  logic [NV-1:0] note_en = '0;
  logic          pwm_l, pwm_r, sample_tick;
  logic [NV-1:0] active;

  int checks = 0;
  int errors = 0;

  synth_poly_pwm #(
    .NVOICES (NV),
    .NSW     (8),
    .ACC_W   (24),
    .PWM_W   (8),
    .ENV_W   (4),
    .ENV_DIV (ENV_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .note_en     (note_en),
    .pwm_l       (pwm_l),
    .pwm_r       (pwm_r),
    .sample_tick (sample_tick),
    .active      (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned inc_tab [8] = '{32'h4000, 32'h47D6, 32'h50A2, 32'h556E,
                               32'h5FE4, 32'h6BA2, 32'h78D1, 32'h8000};
  int unsigned m_acc [NV];
  int          m_env [NV];
  int          m_cnt, m_duty_l, m_duty_r, m_ticks;
  bit          m_pwm_l, m_pwm_r, m_valid;
  // scratch for the model process
  int          s_wf, s_gain, s_oct;
  bit          s_tick, s_nl, s_nr;
  logic [NV-1:0] exp_act;

  function automatic int model_wave(input int unsigned acc, input int wf);
    int ph;
    ph = (acc >> 20) & 15;
    case (wf)
      0:       return (ph >= 8) ? 15 : 0;
      1:       return ph;
      2:       return (ph >= 8) ? 2 * (7 - (ph & 7)) : 2 * (ph & 7);
      default: return (ph >= 12) ? 15 : 0;
    endcase
  endfunction

  function automatic int model_mix(input int sum, input int g);
    int v;
    v = sum >> (3 - g);
    return (v > 255) ? 255 : v;
  endfunction

  // sel: 0 = all voices, 1 = even-index voices, 2 = odd-index voices
  function automatic int model_sum(input int sel, input int wf);
    int s;
    s = 0;
    for (int i = 0; i < NV; i++)
      if (sel == 0 || (sel == 1 && i % 2 == 0) || (sel == 2 && i % 2 == 1))
        s += model_wave(m_acc[i], wf) * m_env[i];
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NV; i++) begin m_acc[i] = 0; m_env[i] = 0; end
      m_cnt = 0; m_duty_l = 0; m_duty_r = 0; m_ticks = 0;
      m_pwm_l = 0; m_pwm_r = 0; m_valid = 1;
    end else if (m_valid) begin
      s_wf   = int'(sw[4:3]);
      s_gain = int'(sw[6:5]);
      s_oct  = int'(sw[2:0]);
      s_tick = (m_cnt == 255);
      s_nl   = (m_cnt < m_duty_l);
`ifdef SYNTH_STEREO_EN
      s_nr   = sw[7] ? (m_cnt < m_duty_r) : s_nl;
`else
      s_nr   = m_pwm_l;
`endif
      if (s_tick) begin
`ifdef SYNTH_STEREO_EN
        m_duty_l = model_mix(model_sum(sw[7] ? 1 : 0, s_wf), s_gain);
        m_duty_r = model_mix(model_sum(sw[7] ? 2 : 0, s_wf), s_gain);
`else
        m_duty_l = model_mix(model_sum(0, s_wf), s_gain);
`endif
        m_ticks++;
        for (int i = 0; i < NV; i++) begin
          m_acc[i] = (m_acc[i] + (inc_tab[i] << s_oct)) & 32'h00FF_FFFF;
          if (m_ticks % ENV_DIV == 0) begin
            if (note_en[i]) m_env[i] = (m_env[i] < 15) ? m_env[i] + 1 : 15;
            else            m_env[i] = (m_env[i] > 0)  ? m_env[i] - 1 : 0;
          end
        end
      end
      m_pwm_l = s_nl;
      m_pwm_r = s_nr;
      m_cnt   = (m_cnt + 1) % 256;
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < NV; i++) exp_act[i] = (m_env[i] != 0);
      check("model_pwm_l", pwm_l, m_pwm_l);
      check("model_pwm_r", pwm_r, m_pwm_r);
      check("model_sample_tick", sample_tick, m_cnt == 255);
      check("model_active", active, exp_act);
    end
  end

  // ---------------- directed sequence ----------------
  task automatic wait_tick(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (!sample_tick && n < 600);
    if (!sample_tick) begin
      checks++; errors++;
      $display("FAIL %s: no sample_tick within 600 clocks", name);
    end
  endtask

  logic [7:0] sw_tab [5] = '{8'h0D, 8'h55, 8'h3E, 8'hF3, 8'h60};

  initial begin
    int n, hi, n225, bad;
    logic prev;

    // Reset held for three clocks.
    rst = 1'b1; sw = 8'h00; note_en = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm_l", pwm_l, 0);
    check("reset_pwm_r", pwm_r, 0);
    check("reset_tick", sample_tick, 0);
    check("reset_active", active, 0);
    rst = 1'b0;

    // First tick 255 clocks after release, then every 256.
    n = 0;
    do begin @(negedge clk); n++; end while (!sample_tick && n < 300);
    check("first_tick_clock", n, 255);
    n = 0;
    do begin @(negedge clk); n++; end while (!sample_tick && n < 300);
    check("tick_period", n, 256);

    // Model pins: saturation / gain shift and waveform shapes.
    check("mix_1125_gain3", model_mix(1125, 3), 255);
    check("mix_1125_gain0", model_mix(1125, 0), 140);
    check("tri_ph9", model_wave(32'h0090_0000, 2), 12);
    check("tri_ph3", model_wave(32'h0030_0000, 2), 6);
    check("pulse_ph12", model_wave(32'h00C0_0000, 3), 15);
    check("pulse_ph11", model_wave(32'h00B0_0000, 3), 0);

    // Voice 0 square, octave 7, gain 3: key press lands on the next env tick.
    note_en = 5'b00001; sw = 8'h67;
    check("active_before_tick", active[0], 0);
    @(negedge clk);
    check("active_after_first_env_tick", active[0], 1);
    repeat (20) wait_tick("ramp_up");
    @(negedge clk);
    n225 = 0;
    for (int p = 0; p < 8; p++) begin
      hi = 0;
      repeat (256) begin @(negedge clk); hi += int'(pwm_l); end
      if (hi != 0) begin check("square_high_period", hi, 225); n225++; end
    end
    check("square_high_periods", n225, 4);

    // Release: 15 env ticks down to zero, then silence.
    wait_tick("release_align");
    note_en = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (active[0] && n < 5000);
    check("release_clocks", n, 1 + 14 * 256);
    repeat (300) @(negedge clk);
    hi = 0;
    repeat (512) begin @(negedge clk); hi += int'(pwm_l | pwm_r); end
    check("silent_after_release", hi, 0);

    // Mid-note reset, then restart from env 0 with the key still held.
    note_en = 5'b00001;
    repeat (5) wait_tick("pre_reset");
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_pwm_l", pwm_l, 0);
    check("midreset_pwm_r", pwm_r, 0);
    check("midreset_active", active, 0);
    check("midreset_tick", sample_tick, 0);
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!active[0] && n < 600);
    check("restart_clocks", n, 256);

    // Voice 0 only with spread requested.
    sw = 8'hE7;
    repeat (20) wait_tick("spread_settle");
    @(negedge clk);
    prev = pwm_l; hi = 0; bad = 0;
    repeat (2048) begin
      @(negedge clk);
      hi += int'(pwm_l);
`ifdef SYNTH_STEREO_EN
      bad += int'(pwm_r);
`else
      bad += int'(pwm_r != prev);
`endif
      prev = pwm_l;
    end
    check("spread_pwm_l_highs", hi, 900);
    check("spread_pwm_r_rule", bad, 0);

    // Mixed voices across waveforms, gains and octaves (model-checked each cycle).
    note_en = 5'b10111;
    for (int k = 0; k < 5; k++) begin
      sw = sw_tab[k];
      repeat (10) wait_tick("mix_run");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
